// File: rtl/mod_addsub_pkg.sv
// Shared constants for the modular add/subtract pipeline: op encoding and the
// width of the signed intermediate that carries x +/- y.
package mod_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // One extra bit holds the add carry or the subtract sign.
  function automatic int ext_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/mod_addsub_core.sv
// Combinational arithmetic for the modular pipeline: the stage-2 candidates
// (t0 = x +/- y, t1 = t0 -/+ M) and the stage-3 selection between them.
module mod_addsub_core
  import mod_addsub_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 13
) (
  input  logic                        a_sub,
  input  logic [WIDTH-1:0]            a_x,
  input  logic [WIDTH-1:0]            a_y,
  output logic [ext_width(WIDTH)-1:0] a_t0,
  output logic [WIDTH-1:0]            a_t1,
  input  logic                        b_sub,
  input  logic [ext_width(WIDTH)-1:0] b_t0,
  input  logic [WIDTH-1:0]            b_t1,
  output logic [WIDTH-1:0]            b_z
);

  localparam int              TW    = ext_width(WIDTH);
  localparam logic [TW-1:0]   M_EXT = TW'(MODULUS);

  // Only the low WIDTH bits of t1 are ever selected, so t1 is kept narrow.
  always_comb begin
    if (a_sub == OP_SUB) begin
      a_t0 = {1'b0, a_x} - {1'b0, a_y};
      a_t1 = WIDTH'(a_t0 + M_EXT);
    end else begin
      a_t0 = {1'b0, a_x} + {1'b0, a_y};
      a_t1 = WIDTH'(a_t0 - M_EXT);
    end
  end

  // Add: t0 is unsigned and wraps once past M. Sub: t0 is two's complement
  // and its top bit marks a borrow that needs M added back.
  always_comb begin
    // NOTE: default first so every path assigns b_z and no latch is inferred.
    b_z = b_t0[WIDTH-1:0];
    if (b_sub == OP_SUB) begin
      if (b_t0[TW-1]) b_z = b_t1;
    end else if (b_t0 >= M_EXT) begin
      b_z = b_t1;
    end
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Three-stage valid/ready pipeline computing (x +/- y) mod M.
// Define MOD_ADDSUB_RANGE_CHECK_EN to flag operands >= M on out_err.
module mod_addsub_pipe
  import mod_addsub_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_err
);

  localparam int TW = ext_width(WIDTH);

  logic             ld1, ld2, ld3, accept;
  logic             s1_valid, s1_sub;
  logic [WIDTH-1:0] s1_x, s1_y;
  logic             s2_valid, s2_sub;
  logic [TW-1:0]    s2_t0;
  logic [WIDTH-1:0] s2_t1;
  logic [TW-1:0]    t0;
  logic [WIDTH-1:0] t1, z;

  // A stage may load when it is empty or its contents move on this cycle.
  assign ld3      = !out_valid || out_ready;
  assign ld2      = !s2_valid  || ld3;
  assign ld1      = !s1_valid  || ld2;
  assign in_ready = ld1 && !rst;
  assign accept   = in_valid && in_ready;

  mod_addsub_core #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_core (
    .a_sub(s1_sub),
    .a_x  (s1_x),
    .a_y  (s1_y),
    .a_t0 (t0),
    .a_t1 (t1),
    .b_sub(s2_sub),
    .b_t0 (s2_t0),
    .b_t1 (s2_t1),
    .b_z  (z)
  );

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the values its predecessor held before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_z     <= '0;
    end else begin
      if (ld1) s1_valid <= accept;
      if (ld2) s2_valid <= s1_valid;
      if (ld3) begin
        out_valid <= s2_valid;
        if (s2_valid) out_z <= z;
      end
    end
  end

  // NOTE: internal data registers carry no reset; the valid bits alone
  // decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_sub <= in_sub;
      s1_x   <= in_x;
      s1_y   <= in_y;
    end
    if (ld2 && s1_valid) begin
      s2_sub <= s1_sub;
      s2_t0  <= t0;
      s2_t1  <= t1;
    end
  end

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  localparam logic [TW-1:0] M_EXT = TW'(MODULUS);

  logic in_err, s1_err, s2_err;

  assign in_err = ({1'b0, in_x} >= M_EXT) || ({1'b0, in_y} >= M_EXT);

  // The flag travels alongside its operation under the same load enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_err <= 1'b0;
    end else begin
      if (accept)               s1_err  <= in_err;
      if (ld2 && s1_valid)      s2_err  <= s1_err;
      if (ld3 && s2_valid)      out_err <= s2_err;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Scoreboard bench for mod_addsub_pipe: directed vectors on a 4-bit/M=13
// instance plus a random-ready run on an 8-bit/M=251 instance.
`timescale 1ns/1ps
module tb_mod_addsub_pipe;

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    logic [7:0] z;
    logic       err;
    bit         chk_z;
    bit         chk_lat;
    int         t_acc;
  } exp_t;

  typedef struct {
    bit sub;
    int x;
    int y;
    int z;
    bit err;
    bit chk_z;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_sub, out_valid, out_ready, out_err;
  logic [3:0] in_x, in_y, out_z;
  logic       in_valid_b, in_ready_b, in_sub_b, out_valid_b, out_ready_b, out_err_b;
  logic [7:0] in_x_b, in_y_b, out_z_b;

  exp_t q1[$];
  exp_t q2[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rand_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod_addsub_pipe #(.WIDTH(4), .MODULUS(13)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sub   (in_sub),
    .in_x     (in_x),
    .in_y     (in_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_z    (out_z),
    .out_err  (out_err)
  );

  mod_addsub_pipe #(.WIDTH(8), .MODULUS(251)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid_b),
    .in_ready (in_ready_b),
    .in_sub   (in_sub_b),
    .in_x     (in_x_b),
    .in_y     (in_y_b),
    .out_valid(out_valid_b),
    .out_ready(out_ready_b),
    .out_z    (out_z_b),
    .out_err  (out_err_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  function automatic int mod_ref(input bit sub, input int x, input int y, input int m);
    int r;
    r = sub ? (x - y) : (x + y);
    r = r % m;
    if (r < 0) r += m;
    return r;
  endfunction

  // Drive one op on the 4-bit DUT starting at a negedge; returns at the
  // negedge after acceptance with in_valid dropped.
  task automatic send1(input bit sub, input int x, input int y, input int ez,
                       input bit eerr, input bit chk_z, input bit lat, input bit push);
    exp_t e;
    bit   acc;
    int   budget;
    acc = 1'b0;
    budget = 0;
    in_valid = 1'b1;
    in_sub   = sub;
    in_x     = x[3:0];
    in_y     = y[3:0];
    while (!acc) begin
      #1;
      acc = in_ready;
      if (acc && push) begin
        e.z = ez[7:0]; e.err = eerr; e.chk_z = chk_z; e.chk_lat = lat; e.t_acc = cyc;
        q1.push_back(e);
      end
      @(negedge clk);
      if (!acc && ++budget > 200) begin
        fail("send1 timeout");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send2(input bit sub, input int x, input int y);
    exp_t e;
    bit   acc;
    int   budget;
    acc = 1'b0;
    budget = 0;
    in_valid_b = 1'b1;
    in_sub_b   = sub;
    in_x_b     = x[7:0];
    in_y_b     = y[7:0];
    while (!acc) begin
      #1;
      acc = in_ready_b;
      if (acc) begin
        e.z = 8'(mod_ref(sub, x, y, 251)); e.err = 1'b0; e.chk_z = 1'b1;
        e.chk_lat = 1'b0; e.t_acc = cyc;
        q2.push_back(e);
      end
      @(negedge clk);
      if (!acc && ++budget > 200) begin
        fail("send2 timeout");
        break;
      end
    end
    in_valid_b = 1'b0;
  endtask

  task automatic drain(input bit which);
    int budget;
    budget = 0;
    while ((which ? q2.size() : q1.size()) != 0) begin
      @(negedge clk);
      #3;
      if (++budget > 500) begin
        fail(which ? "drain b timeout" : "drain timeout");
        break;
      end
    end
  endtask

  // Monitor for the 4-bit DUT: pops on each transfer and checks stall hold.
  always @(negedge clk) begin : mon1
    exp_t       e;
    logic [3:0] held_z;
    logic       held_err;
    bit         stalled;
    #2;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold valid", out_valid, 1);
        check("hold z", out_z, held_z);
        check("hold err", out_err, held_err);
      end
      if (out_valid && out_ready) begin
        if (q1.size() == 0) begin
          fail("unexpected out_valid");
        end else begin
          e = q1.pop_front();
          if (e.chk_z) check("out_z", out_z, e.z[3:0]);
          check("out_err", out_err, e.err);
          if (e.chk_lat) check("latency", cyc - e.t_acc, 3);
        end
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled  = 1'b1;
        held_z   = out_z;
        held_err = out_err;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t       e;
    logic [7:0] held_z;
    bit         stalled;
    #2;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold valid b", out_valid_b, 1);
        check("hold z b", out_z_b, held_z);
      end
      if (out_valid_b && out_ready_b) begin
        if (q2.size() == 0) begin
          fail("unexpected out_valid b");
        end else begin
          e = q2.pop_front();
          check("out_z b", out_z_b, e.z);
          check("out_err b", out_err_b, e.err);
        end
        stalled = 1'b0;
      end else if (out_valid_b) begin
        stalled = 1'b1;
        held_z  = out_z_b;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dv[9];
    vec_t bp[5];
    bit   saw_low;

    dv = '{'{1'b0, 9, 7, 3, 1'b0, 1'b1},   '{1'b0, 12, 0, 12, 1'b0, 1'b1},
           '{1'b0, 6, 7, 0, 1'b0, 1'b1},   '{1'b1, 3, 9, 7, 1'b0, 1'b1},
           '{1'b1, 9, 3, 6, 1'b0, 1'b1},   '{1'b1, 0, 0, 0, 1'b0, 1'b1},
           '{1'b1, 0, 12, 1, 1'b0, 1'b1},  '{1'b0, 12, 12, 11, 1'b0, 1'b1},
           '{1'b0, 14, 1, 0, RC, 1'b0}};
    bp = '{'{1'b0, 1, 2, 3, 1'b0, 1'b1},   '{1'b0, 12, 12, 11, 1'b0, 1'b1},
           '{1'b1, 5, 7, 11, 1'b0, 1'b1},  '{1'b1, 10, 4, 6, 1'b0, 1'b1},
           '{1'b0, 8, 9, 4, 1'b0, 1'b1}};

    rst = 1'b1;
    in_valid = 1'b0; in_sub = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
    in_valid_b = 1'b0; in_sub_b = 1'b0; in_x_b = '0; in_y_b = '0; out_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3;
    check("reset out_valid", out_valid, 0);
    check("reset out_z", out_z, 0);
    check("reset out_err", out_err, 0);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid b", out_valid_b, 0);
    @(negedge clk);

    // Isolated directed ops, each with a 3-cycle latency check.
    foreach (dv[i]) begin
      send1(dv[i].sub, dv[i].x, dv[i].y, dv[i].z, dv[i].err, dv[i].chk_z, 1'b1, 1'b1);
      drain(1'b0);
      @(negedge clk);
    end

    // Back-to-back burst: one result per cycle, each still 3 cycles late.
    foreach (bp[i]) send1(bp[i].sub, bp[i].x, bp[i].y, bp[i].z, 1'b0, 1'b1, 1'b1, 1'b1);
    drain(1'b0);
    @(negedge clk);

    // Backpressure: out_ready low for cycles 4..7 of the burst.
    saw_low = 1'b0;
    fork
      foreach (bp[i]) send1(bp[i].sub, bp[i].x, bp[i].y, bp[i].z, 1'b0, 1'b1, 1'b0, 1'b1);
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
      begin
        repeat (10) begin
          @(negedge clk);
          #1;
          if (!in_ready) saw_low = 1'b1;
        end
      end
    join
    drain(1'b0);
    check("in_ready dropped when full", saw_low, 1);
    @(negedge clk);

    // Reset mid-flight: two ops in the pipe, rst in cycle 2 with in_valid high.
    send1(1'b0, 4, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send1(1'b1, 7, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1; in_sub = 1'b0; in_x = 4'd3; in_y = 4'd3;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #3;
      check("no stale out_valid", out_valid, 0);
    end
    @(negedge clk);
    send1(1'b0, 5, 6, 11, 1'b0, 1'b1, 1'b1, 1'b1);
    drain(1'b0);

    // Random compare on the 8-bit instance with random out_ready.
    @(negedge clk);
    fork
      begin
        for (int n = 0; n < 10000; n++)
          send2(1'($urandom_range(0, 1)), $urandom_range(0, 250), $urandom_range(0, 250));
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready_b = 1'($urandom_range(0, 1));
        end
        out_ready_b = 1'b1;
      end
    join
    drain(1'b1);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
